// File: rtl/axis_pcie_pkg.sv
// Shared types and constants for the PCIe RX framing path.
// Holds the framer state encoding, the header field layout and the drop counter width.
package axis_pcie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_DROP      = 3'd2,
    ST_SEND_HDR  = 3'd3,
    ST_SEND_DATA = 3'd4
  } tlp_state_e;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 15;
  localparam int DROP_CNT_W  = 16;

  // Reserved header bits [31:16] are always zero.
  function automatic logic [31:0] make_hdr(input logic [15:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/tlp_buf_ram.sv
// Simple dual-port DEPTH x 32 buffer: synchronous write, registered read.
// The read register holds its value while rd_en is low, which the framer uses as a prefetch stage.
module tlp_buf_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_tlp_rx_framer.sv
// Store-and-forward TLP framer: buffers one TLAST-delimited TLP, then emits a length
// header followed by the buffered dwords; oversized TLPs are discarded and counted.
module axis_tlp_rx_framer
  import axis_pcie_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LEN_W = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [31:0]           S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DROP_CNT_W-1:0] DROP_COUNT,
  output logic                  BUSY
);

  localparam int AW = LEN_W - 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  tlp_state_e            state_q, state_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [LEN_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]      rd_ptr_nxt;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  rdy_en_q;

  logic          in_fire;
  logic          at_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  // Input side stays closed until the first clock edge after reset release.
  assign S_AXIS_TREADY = rdy_en_q &&
                         (state_q inside {ST_IDLE, ST_FILL, ST_DROP});
  assign in_fire       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign rd_ptr_nxt    = rd_ptr_q + LEN_W'(1);
  assign at_last       = (rd_ptr_q == (count_q - LEN_W'(1)));

  assign M_AXIS_TVALID = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA);
  assign M_AXIS_TLAST  = (state_q == ST_SEND_DATA) && at_last;
  assign BUSY          = (state_q != ST_IDLE);
  assign DROP_COUNT    = drop_cnt_q;

  always_comb begin
    M_AXIS_TDATA = '0;
    if (state_q == ST_SEND_HDR) begin
      M_AXIS_TDATA = make_hdr(16'(count_q));
    end else if (state_q == ST_SEND_DATA) begin
      M_AXIS_TDATA = rd_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    wr_addr    = count_q[AW-1:0];
    rd_en      = 1'b0;
    rd_addr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = LEN_W'(1);
          state_d = S_AXIS_TLAST ? ST_SEND_HDR : ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_fire) begin
          if (count_q == DEPTH_L) begin
            drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q
                                            : drop_cnt_q + DROP_CNT_W'(1);
            count_d    = '0;
            state_d    = S_AXIS_TLAST ? ST_IDLE : ST_DROP;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + LEN_W'(1);
            if (S_AXIS_TLAST) begin
              state_d = ST_SEND_HDR;
            end
          end
        end
      end
      ST_DROP: begin
        if (in_fire && S_AXIS_TLAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_HDR: begin
        // Word 0 is fetched while the header is on the bus so data follows without a bubble.
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_ptr_d = '0;
        if (M_AXIS_TREADY) begin
          state_d = ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (M_AXIS_TREADY) begin
          if (at_last) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = rd_ptr_nxt[AW-1:0];
            rd_ptr_d = rd_ptr_nxt;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  tlp_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (ACLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (S_AXIS_TDATA),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_axis_tlp_rx_framer.sv
// Randomised self-checking bench for axis_tlp_rx_framer against a frame-level reference model.
module tb_axis_tlp_rx_framer;

  localparam int DEPTH = 1024;
  localparam int LEN_W = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] drop_count;
  logic        busy;

  axis_tlp_rx_framer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .DROP_COUNT    (drop_count),
    .BUSY          (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int stall_err = 0;
  int last_in_cyc = 0;
  int rdy_mode = 0;      // 0: always ready, 1: random, 2: manual_rdy
  logic manual_rdy = 1'b1;

  logic [31:0] capt_data[$];
  logic        capt_last[$];
  int          capt_cyc[$];
  logic [31:0] exp_data[$];
  logic        exp_last[$];
  logic [31:0] tx_q[$];
  int          drop_model = 0;

  // Output monitor: samples on the falling edge, records beats that will handshake next rising edge.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
          stall_err++;
        if (m_tvalid && m_tready) begin
          capt_data.push_back(m_tdata);
          capt_last.push_back(m_tlast);
          capt_cyc.push_back(cyc);
        end
        if (s_tvalid && s_tready && s_tlast) last_in_cyc = cyc;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  // Downstream ready generator.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0)      m_tready = 1'b1;
      else if (rdy_mode == 1) m_tready = ($urandom_range(0, 2) != 0);
      else                    m_tready = manual_rdy;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a TLP of N <= DEPTH words becomes header N then the words, TLAST on the
  // final word; a longer TLP produces nothing and bumps a saturating drop counter.
  task automatic model_tlp();
    if (tx_q.size() <= DEPTH) begin
      exp_data.push_back(32'(tx_q.size()));
      exp_last.push_back(1'b0);
      for (int i = 0; i < tx_q.size(); i++) begin
        exp_data.push_back(tx_q[i]);
        exp_last.push_back(i == tx_q.size() - 1);
      end
    end else begin
      drop_model = (drop_model >= 65535) ? 65535 : drop_model + 1;
    end
  endtask

  task automatic make_tx(input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back($urandom());
  endtask

  task automatic send_tx(input bit gaps);
    for (int i = 0; i < tx_q.size(); i++) begin
      bit acc;
      int n;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = tx_q[i];
      s_tlast  = (i == tx_q.size() - 1);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 5000) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        tot_cnt++;
        $display("FAIL send_timeout word %0d got no TREADY want TREADY=1", i);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (capt_data.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic clear_queues();
    capt_data.delete(); capt_last.delete(); capt_cyc.delete();
    exp_data.delete();  exp_last.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    tot_cnt++;
    if ({s_tready, m_tvalid, m_tlast, m_tdata, drop_count, busy} !== '0)
      $display("FAIL reset_outputs got tready=%b tvalid=%b tlast=%b tdata=%h drop=%h busy=%b want all 0",
               s_tready, m_tvalid, m_tlast, m_tdata, drop_count, busy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tot_cnt++;
    if (s_tready !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0)
      $display("FAIL reset_release got tready=%b busy=%b tvalid=%b want 1/0/0", s_tready, busy, m_tvalid);
    else pass_cnt++;
  endtask

  task automatic test_three_dword();
    rdy_mode = 0;
    @(posedge clk); #1;
    tx_q = {32'h4A000001, 32'h01000004, 32'hDEADBEEF};
    model_tlp();
    send_tx(1'b0);
    wait_beats(4, 200);
    tot_cnt++;
    if (capt_data.size() != exp_data.size())
      $display("FAIL three_count got %0d beats want %0d", capt_data.size(), exp_data.size());
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < exp_data.size(); i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL three_beat[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    if (capt_cyc.size() == 4) begin
      tot_cnt++;
      if (capt_cyc[0] != last_in_cyc + 1)
        $display("FAIL three_hdr_latency got cycle %0d want %0d", capt_cyc[0], last_in_cyc + 1);
      else pass_cnt++;
      tot_cnt++;
      if (capt_cyc[3] - capt_cyc[0] != 3)
        $display("FAIL three_bubbles got span %0d want 3", capt_cyc[3] - capt_cyc[0]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (s_tready !== 1'b1 || busy !== 1'b0)
      $display("FAIL back_to_back_ready got tready=%b busy=%b want 1/0", s_tready, busy);
    else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_single_dword();
    rdy_mode = 1;
    stall_err = 0;
    tx_q = {32'h12345678};
    model_tlp();
    send_tx(1'b1);
    wait_beats(2, 500);
    tot_cnt++;
    if (capt_data.size() != 2)
      $display("FAIL single_count got %0d beats want 2", capt_data.size());
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < exp_data.size(); i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL single_beat[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (stall_err != 0) $display("FAIL single_stall_stable got %0d violations want 0", stall_err);
    else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_random_stream();
    rdy_mode = 1;
    stall_err = 0;
    for (int f = 0; f < 8; f++) begin
      make_tx($urandom_range(1, 16));
      model_tlp();
      send_tx(1'b1);
    end
    wait_beats(exp_data.size(), 5000);
    tot_cnt++;
    if (capt_data.size() != exp_data.size())
      $display("FAIL stream_count got %0d beats want %0d", capt_data.size(), exp_data.size());
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < exp_data.size(); i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL stream_beat[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (stall_err != 0) $display("FAIL stream_stall_stable got %0d violations want 0", stall_err);
    else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_reset_mid_frame();
    int k;
    rdy_mode = 2;
    manual_rdy = 1'b1;
    make_tx(5);
    model_tlp();
    send_tx(1'b0);
    k = 0;
    while (capt_data.size() < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    manual_rdy = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if (capt_data.size() != 3)
      $display("FAIL midrst_progress got %0d beats want 3", capt_data.size());
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < 3; i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL midrst_beat[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_data[3] || busy !== 1'b1)
      $display("FAIL midrst_hold got valid=%b data=%h busy=%b want 1/%h/1", m_tvalid, m_tdata, busy, exp_data[3]);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    tot_cnt++;
    if ({m_tvalid, m_tlast, m_tdata, busy, s_tready} !== '0 || drop_count !== 16'(drop_model))
      $display("FAIL midrst_clear got valid=%b last=%b data=%h busy=%b tready=%b drop=%h want 0s drop=%h",
               m_tvalid, m_tlast, m_tdata, busy, s_tready, drop_count, 16'(drop_model));
    else pass_cnt++;
    clear_queues();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    tot_cnt++;
    if (s_tready !== 1'b1) $display("FAIL midrst_ready got %b want 1", s_tready);
    else pass_cnt++;
    make_tx(4);
    model_tlp();
    send_tx(1'b1);
    wait_beats(5, 200);
    tot_cnt++;
    if (capt_data.size() != 5) $display("FAIL midrst_next_count got %0d want 5", capt_data.size());
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < exp_data.size(); i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL midrst_next[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    clear_queues();
  endtask

  task automatic test_depth_boundary();
    rdy_mode = 0;
    make_tx(DEPTH);
    model_tlp();
    send_tx(1'b0);
    wait_beats(DEPTH + 1, 3000);
    tot_cnt++;
    if (capt_data.size() != DEPTH + 1)
      $display("FAIL depth_count got %0d beats want %0d", capt_data.size(), DEPTH + 1);
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < exp_data.size(); i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL depth_beat[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    clear_queues();
    make_tx(DEPTH + 1);
    model_tlp();
    send_tx(1'b0);
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL over_idle got busy=%b want 0", busy);
    else pass_cnt++;
    repeat (4) begin @(posedge clk); #1; end
    tot_cnt++;
    if (drop_count !== 16'(drop_model) || capt_data.size() != 0)
      $display("FAIL over_drop got drop=%h beats=%0d want drop=%h beats=0", drop_count, capt_data.size(), 16'(drop_model));
    else pass_cnt++;
    make_tx(2);
    model_tlp();
    send_tx(1'b1);
    wait_beats(3, 200);
    tot_cnt++;
    if (capt_data.size() != 3) $display("FAIL after_drop_count got %0d want 3", capt_data.size());
    else pass_cnt++;
    for (int i = 0; i < capt_data.size() && i < exp_data.size(); i++) begin
      tot_cnt++;
      if (capt_data[i] !== exp_data[i] || capt_last[i] !== exp_last[i])
        $display("FAIL after_drop[%0d] got %h/%b want %h/%b", i, capt_data[i], capt_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    clear_queues();
  endtask

  task automatic test_drop_saturation();
    int lens[3];
    lens = '{DEPTH + 1, DEPTH + 6, DEPTH + 40};
    rdy_mode = 0;
    @(posedge clk); #1;
    force dut.drop_cnt_q = 16'hFFFE;
    #2;
    release dut.drop_cnt_q;
    drop_model = 16'hFFFE;
    @(posedge clk); #1;
    tot_cnt++;
    if (drop_count !== 16'hFFFE) $display("FAIL sat_preset got %h want fffe", drop_count);
    else pass_cnt++;
    for (int t = 0; t < 3; t++) begin
      make_tx(lens[t]);
      model_tlp();
      send_tx(1'b1);
      repeat (3) begin @(posedge clk); #1; end
      tot_cnt++;
      if (drop_count !== 16'(drop_model) || capt_data.size() != 0 || busy !== 1'b0)
        $display("FAIL sat_drop[%0d] got drop=%h beats=%0d busy=%b want drop=%h beats=0 busy=0",
                 t, drop_count, capt_data.size(), busy, 16'(drop_model));
      else pass_cnt++;
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_three_dword();
    test_single_dword();
    test_random_stream();
    test_reset_mid_frame();
    test_depth_boundary();
    test_drop_saturation();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/axis_tlp_rx_framer.md
Name: axis_tlp_rx_framer

Overview:
Store-and-forward framer placed directly downstream of the PCIe transaction RX stream and upstream of the Microblaze-facing S0_AXIS slave port of axis_pcie.
- Buffers one complete TLP, delimited by TLAST, from a 32-bit AXIS input.
- Emits a length header word, then the buffered TLP dwords, on a 32-bit AXIS output, so firmware knows the frame size before reading.
- Silently discards TLPs longer than the buffer and counts each discard.

Parameters:
DEPTH, 1024, buffer size in 32-bit words; power of two, >= 4; also the maximum accepted TLP length.
LEN_W, 11, width of the length counter; must equal log2(DEPTH)+1.

Ports:
ACLK  in  1  sole clock; all logic is on the rising edge.
ARESETN  in  1  asynchronous active-low reset.
S_AXIS_TDATA  in  32  TLP dword in.
S_AXIS_TLAST  in  1  last dword of the TLP.
S_AXIS_TVALID  in  1  input word valid.
S_AXIS_TREADY  out  1  input accepted when TVALID&TREADY.
M_AXIS_TDATA  out  32  header or TLP dword out.
M_AXIS_TLAST  out  1  last dword of the frame.
M_AXIS_TVALID  out  1  output word valid.
M_AXIS_TREADY  in  1  downstream ready.
DROP_COUNT  out  16  number of discarded TLPs; saturates at 16'hFFFF.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (ARESETN=0, asynchronous): state=IDLE; word count=0; S_AXIS_TREADY=0 while reset is asserted; M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, DROP_COUNT=0, BUSY=0. Buffered contents are discarded. Reset mid-frame aborts the frame without a drop count. One cycle after deassertion: S_AXIS_TREADY=1.
- States: IDLE, FILL, DROP, SEND_HDR, SEND_DATA.
- IDLE: S_AXIS_TREADY=1. On an accepted word: write it to address 0, set count=1.
  - If TLAST=1, go to SEND_HDR.
  - Otherwise go to FILL.
- FILL: S_AXIS_TREADY=1. Each accepted word is written at address count, then count increments.
  - Accepted word with TLAST=1 and count<DEPTH before the write: go to SEND_HDR. Frame length is count+1, so DEPTH words are legal.
  - Accepted word with count==DEPTH (overflow): do not write it; DROP_COUNT+=1 (saturating).
    - If that word also has TLAST=1, go to IDLE.
    - Otherwise go to DROP.
- DROP: S_AXIS_TREADY=1; words are discarded. An accepted word with TLAST=1 goes to IDLE.
- SEND_HDR: S_AXIS_TREADY=0.
  - M_AXIS_TVALID=1, M_AXIS_TDATA={16'h0000, zero-extended length}, M_AXIS_TLAST=0.
  - Header is valid the cycle after the input TLAST handshake.
  - On M_AXIS_TREADY go to SEND_DATA.
- SEND_DATA: S_AXIS_TREADY=0.
  - Words are output in address order 0..length-1; TLAST=1 on word length-1.
  - Once TLAST is accepted, go to IDLE with count=0.
  - Sustains one word per cycle while M_AXIS_TREADY=1, with no bubble between the header and data, or between data words. RAM read latency is hidden by prefetch.
- AXIS rules:
  - TDATA and TLAST are held stable while TVALID=1 and TREADY=0.
  - TVALID never drops without a handshake.
  - M_AXIS_TVALID=0 in IDLE, FILL and DROP.
- No input is accepted during SEND_HDR or SEND_DATA; upstream back-pressure covers this.
- Back-to-back: a new TLP can be accepted in the cycle after the final output handshake.
- Single-dword TLP: header length=1, then one data word with TLAST=1.
- DROP_COUNT increments once per discarded TLP, never per word. It holds at 16'hFFFF.

Decomposition:
- Shared package axis_pcie_pkg holds:
  - state enum;
  - header field constants: HDR_LEN_LSB=0, HDR_LEN_MSB=15, reserved bits [31:16]=0;
  - DROP_COUNT width.
- One sub-module, tlp_buf_ram: simple dual-port RAM, DEPTH x 32.
  - Write port: synchronous.
  - Read port: synchronous, one-cycle latency.
  - Infers block RAM.

Test Plan:
- Reset with inputs idle: all outputs 0. One cycle after deassertion: S_AXIS_TREADY=1, BUSY=0.
- 3-dword TLP 32'h4A000001, 32'h01000004, 32'hDEADBEEF with M_AXIS_TREADY=1. Output must be 32'h00000003, then the three dwords with TLAST only on 32'hDEADBEEF. Header appears one cycle after the input TLAST, and there are no bubbles.
- 1-dword TLP 32'h12345678 with random M_AXIS_TREADY toggling: header 32'h00000001, then 32'h12345678 with TLAST. Data must stay stable during stalls.
- DEPTH-word TLP (1024 words) is forwarded with header 32'h00000400. A following 1025-word TLP is dropped: DROP_COUNT=1, no output, FSM returns to IDLE after the TLAST. A next 2-word TLP is forwarded correctly.
- ARESETN pulsed low in SEND_DATA after 2 of 5 words: outputs clear immediately and DROP_COUNT is unchanged. The next TLP is framed correctly from address 0.
- Force DROP_COUNT to 16'hFFFE, then drop 3 oversized TLPs: DROP_COUNT=16'hFFFF and holds.
